mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 38 +++
 rtl/mem_arbiter.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the two-port memory arbiter.
//   arb_state_e    - arbiter FSM states (idle, memory busy, response)
//   Grant*         - one-hot grant encodings, bit0 = port 0 (I-cache)
//   Default*       - default address width, line width and timeout
//   rr_pick()      - round-robin winner selection between the two ports
package mem_arb_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StResp
    } arb_state_e;

    localparam logic [1:0] GrantNone = 2'b00;
    localparam logic [1:0] GrantP0   = 2'b01;
    localparam logic [1:0] GrantP1   = 2'b10;

    localparam int unsigned DefaultAddrW   = 32;
    localparam int unsigned DefaultDataW   = 256;
    localparam int unsigned DefaultTimeout = 255;

    // On a tie the port that did not win last time is chosen.
    function automatic logic [1:0] rr_pick(input logic       en0,
                                           input logic       en1,
                                           input logic [1:0] last);
        logic [1:0] pick;
        pick = GrantNone;
        if (en0 && en1) begin
            pick = (last == GrantP0) ? GrantP1 : GrantP0;
        end else if (en0) begin
            pick = GrantP0;
        end else if (en1) begin
            pick = GrantP1;
        end
        return pick;
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates an instruction cache (p0) and a data cache (p1) onto
// one shared memory port, one transaction at a time.
//   clk_i, rst_i            - clock, asynchronous active-low reset
//   p0_* / p1_*             - cache request (enable, write, addr, data) and
//                             response (one-cycle ack, read data)
//   mem_*                   - shared memory request and response handshake
//   busy_o                  - a memory transaction is in flight
//   grant_o                 - one-hot owner of the memory port while busy
//   timeout_o               - sticky: a transaction was force-completed
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = DefaultAddrW,
    parameter int unsigned DATA_W  = DefaultDataW,
    parameter int unsigned TIMEOUT = DefaultTimeout
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              p0_enable_i,
    input  logic              p0_write_i,
    input  logic [ADDR_W-1:0] p0_addr_i,
    input  logic [DATA_W-1:0] p0_data_i,
    output logic              p0_ack_o,
    output logic [DATA_W-1:0] p0_data_o,

    input  logic              p1_enable_i,
    input  logic              p1_write_i,
    input  logic [ADDR_W-1:0] p1_addr_i,
    input  logic [DATA_W-1:0] p1_data_i,
    output logic              p1_ack_o,
    output logic [DATA_W-1:0] p1_data_o,

    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    input  logic [DATA_W-1:0] mem_data_i,
    input  logic              mem_ack_i,

    output logic              busy_o,
    output logic [1:0]        grant_o,
    output logic              timeout_o
);

    localparam int unsigned    CntW   = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT);

    arb_state_e        state_q, state_d;
    logic [1:0]        win_q, win_d;
    logic [1:0]        last_q, last_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              timeout_q, timeout_d;

    logic [1:0]        pick;
    logic              in_busy;
    logic              in_resp;

    assign pick    = rr_pick(p0_enable_i, p1_enable_i, last_q);
    assign in_busy = (state_q == StBusy);
    assign in_resp = (state_q == StResp);

    always_comb begin
        state_d   = state_q;
        win_d     = win_q;
        last_d    = last_q;
        write_d   = write_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;

        unique case (state_q)
            StIdle: begin
                if (pick != GrantNone) begin
                    win_d   = pick;
                    cnt_d   = '0;
                    state_d = StBusy;
                    if (pick == GrantP0) begin
                        write_d = p0_write_i;
                        addr_d  = p0_addr_i;
                        wdata_d = p0_data_i;
                    end else begin
                        write_d = p1_write_i;
                        addr_d  = p1_addr_i;
                        wdata_d = p1_data_i;
                    end
                end
            end
            StBusy: begin
                cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
                if (mem_ack_i) begin
                    if (!write_q) begin
                        rdata_d = mem_data_i;
                    end
                    state_d = StResp;
                end else if (cnt_d == CntMax) begin
                    // Memory never answered: finish the transaction with zero read data.
                    timeout_d = 1'b1;
                    if (!write_q) begin
                        rdata_d = '0;
                    end
                    state_d = StResp;
                end
            end
            StResp: begin
                last_d  = win_q;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= StIdle;
            win_q     <= GrantNone;
            last_q    <= GrantP1;  // p0 wins the first tie
            write_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            win_q     <= win_d;
            last_q    <= last_d;
            write_q   <= write_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    // Outputs decode directly from state so an asynchronous reset drops them at once.
    assign mem_enable_o = in_busy;
    assign mem_write_o  = in_busy & write_q;
    assign mem_addr_o   = in_busy ? addr_q : '0;
    assign mem_data_o   = in_busy ? wdata_q : '0;
    assign busy_o       = in_busy;
    assign grant_o      = in_busy ? win_q : GrantNone;
    assign p0_ack_o     = in_resp & win_q[0];
    assign p1_ack_o     = in_resp & win_q[1];
    assign p0_data_o    = rdata_q;
    assign p1_data_o    = rdata_q;
    assign timeout_o    = timeout_q;

endmodule
